// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader and registered fetch port for the instruction memory
//
// Purpose : Write side of the DEPTH x DW instruction memory. Bytes arriving on a
//           valid/ready stream are packed MSB-first into DW-bit words and written
//           sequentially from address 0. The CPU is held in reset (cpu_hold) until
//           a load completes. The read side is a registered 1-cycle fetch port.
// Ports   : clk, clkreset       - clock, synchronous active-high reset
//           start, word_count   - load request and number of words (1..DEPTH)
//           byte_valid/data/ready - incoming byte stream handshake
//           busy, done          - load in progress, 1-cycle completion pulse
//           cpu_hold            - keeps the processor in reset
//           words_written       - words written in the current or last load
//           err                 - sticky error (illegal word_count, checksum mismatch)
//           fetch_addr/data     - fetch read port, data registered one cycle after addr
// Options : define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after
//           the last word; a mismatch sets err and leaves cpu_hold asserted.
module imem_loader #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          clkreset,
   input  logic          start,
   input  logic [AW:0]   word_count,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   output logic          byte_ready,
   output logic          busy,
   output logic          done,
   output logic          cpu_hold,
   output logic [AW:0]   words_written,
   output logic          err,
   input  logic [AW-1:0] fetch_addr,
   output logic [DW-1:0] fetch_data
);

   localparam int BPW = DW / 8;
   localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [BIW-1:0] LAST_IDX = BIW'(BPW - 1);
   localparam logic [BIW-1:0] IDX_ONE  = BIW'(1);
   localparam logic [AW:0]    WW_ONE   = (AW + 1)'(1);
   localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
   localparam logic [AW:0]    DEPTH_W  = (AW + 1)'(DEPTH);

`ifdef LOADER_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

   state_t         state, state_nxt;
   logic [AW:0]    count_q;
   logic [AW-1:0]  wr_ptr;
   logic [BIW-1:0] byte_idx;
   logic [DW-1:0]  acc;
   logic [DW-1:0]  acc_next;
   logic [DW-1:0]  mem [DEPTH];
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]     csum;
`endif

   logic xfer;
   logic word_end;
   logic last_word;
   logic start_ok;

   assign xfer      = byte_valid && byte_ready;
   assign start_ok  = start && (word_count != '0) && (word_count <= DEPTH_W);
   // Accumulator after shifting in the current byte; also the word written
   // when this byte completes it.
   assign acc_next  = (acc << 8) | DW'(byte_data);
   assign word_end  = (state == LOAD) && xfer && (byte_idx == LAST_IDX);
   assign last_word = ((words_written + WW_ONE) == count_q);

   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = LOAD;
         end
         LOAD: begin
            busy       = 1'b1;
            byte_ready = 1'b1;
            if (word_end && last_word) begin
`ifdef LOADER_CHECKSUM_EN
               state_nxt = CHECK;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            busy       = 1'b1;
            byte_ready = 1'b1;
            if (byte_valid) state_nxt = DONE;
         end
`endif
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clkreset) begin
         state         <= IDLE;
         count_q       <= '0;
         wr_ptr        <= '0;
         byte_idx      <= '0;
         acc           <= '0;
         words_written <= '0;
         err           <= 1'b0;
         cpu_hold      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
         csum          <= '0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start_ok) begin
                  count_q       <= word_count;
                  wr_ptr        <= '0;
                  byte_idx      <= '0;
                  words_written <= '0;
                  err           <= 1'b0;
                  cpu_hold      <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                  csum          <= '0;
`endif
               end else if (start) begin
                  err <= 1'b1;
               end
            end
            LOAD: begin
               if (xfer) begin
                  acc      <= acc_next;
                  byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_ONE;
`ifdef LOADER_CHECKSUM_EN
                  csum     <= csum ^ byte_data;
`endif
                  if (word_end) begin
                     words_written <= words_written + WW_ONE;
                     // Hold the pointer on the final word so a full-depth
                     // load never wraps back to address 0.
                     if (!last_word) wr_ptr <= wr_ptr + PTR_ONE;
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHECK: begin
               if (xfer && (byte_data != csum)) err <= 1'b1;
            end
`endif
            DONE: begin
               // err can only be set here by a failed checksum check.
               if (!err) cpu_hold <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Memory contents survive reset; only the write strobe is gated by it.
   always_ff @(posedge clk) begin
      if (word_end && !clkreset) mem[wr_ptr] <= acc_next;
   end

   // Read-before-write: a same-edge write to fetch_addr returns the old word.
   always_ff @(posedge clk) begin
      if (clkreset) fetch_data <= '0;
      else          fetch_data <= mem[fetch_addr];
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          clkreset;
   logic          start;
   logic [AW:0]   word_count;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          busy;
   logic          done;
   logic          cpu_hold;
   logic [AW:0]   words_written;
   logic          err;
   logic [AW-1:0] fetch_addr;
   logic [DW-1:0] fetch_data;

   always #5 clk = ~clk;

   imem_loader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .clkreset(clkreset), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .busy(busy), .done(done), .cpu_hold(cpu_hold), .words_written(words_written),
      .err(err), .fetch_addr(fetch_addr), .fetch_data(fetch_data)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_mem [DEPTH];
   bit          known   [DEPTH];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference packing: word k is bytes 4k..4k+3 read as a big-endian number.
   function automatic logic [31:0] pack_word(input logic [7:0] q[$], input int k);
      logic [31:0] w = 0;
      for (int j = 0; j < 4; j++) w = (w * 32'd256) + 32'(q[4*k + j]);
      return w;
   endfunction

   task automatic fetch_check(input int a, input string tag);
      fetch_addr = AW'(a);
      tick();
      check(tag, fetch_data, exp_mem[a]);
   endtask

   task automatic verify_known(input string tag);
      for (int a = 0; a < DEPTH; a++)
         if (known[a]) fetch_check(a, tag);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int idle;
      int t;
      idle = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      byte_valid = 1'b0;
      repeat (idle) tick();
      byte_valid = 1'b1;
      byte_data  = b;
      t = 0;
      while (byte_ready !== 1'b1 && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) check("byte_ready_timeout", byte_ready, 1);
      tick();
      byte_valid = 1'b0;
   endtask

   task automatic do_start(input int n);
      start      = 1'b1;
      word_count = (AW + 1)'(n);
      tick();
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_ready", byte_ready, 1);
      check("start_err", err, 0);
      check("start_hold", cpu_hold, 1);
      check("start_ww", words_written, 0);
   endtask

   task automatic run_load(input int n, input logic [7:0] q[$], input int gap,
                           input bit chk_ok, input bit poke);
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] x = 8'h00;
`endif
      do_start(n);
      foreach (q[i]) begin
         send_byte(q[i], gap);
`ifdef LOADER_CHECKSUM_EN
         x ^= q[i];
`endif
         if (poke && i == 0) begin
            start      = 1'b1;
            word_count = '0;
            tick();
            start = 1'b0;
            check("busy_start_err", err, 0);
            check("busy_start_busy", busy, 1);
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(chk_ok ? x : (x ^ 8'h01), gap);
`endif
      check("done_pulse", done, 1);
      check("done_busy", busy, 1);
      check("done_ready", byte_ready, 0);
      check("done_ww", words_written, 32'(n));
      for (int k = 0; k < n; k++) begin
         exp_mem[k] = pack_word(q, k);
         known[k]   = 1'b1;
      end
      tick();
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_hold", cpu_hold, chk_ok ? 0 : 1);
      check("post_err", err, chk_ok ? 0 : 1);
   endtask

   initial begin
      logic [7:0]  q[$];
      logic [31:0] old_w;
      int          n;

      clkreset = 1'b1; start = 1'b0; word_count = '0;
      byte_valid = 1'b0; byte_data = '0; fetch_addr = '0;
      for (int a = 0; a < DEPTH; a++) known[a] = 1'b0;
      tick(); tick();
      check("rst_ready", byte_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_hold", cpu_hold, 1);
      check("rst_ww", words_written, 0);
      check("rst_err", err, 0);
      check("rst_fetch", fetch_data, 0);
      clkreset = 1'b0;
      tick();

      // Back-to-back two-word load
      q = {8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      run_load(2, q, 0, 1'b1, 1'b0);
      fetch_addr = 0; tick(); check("b2b_mem0", fetch_data, 32'h12345678);
      fetch_addr = 1; tick(); check("b2b_mem1", fetch_data, 32'h9ABCDEF0);

      // Same load with valid toggling every other cycle
      run_load(2, q, 1, 1'b1, 1'b0);
      fetch_addr = 0; tick(); check("gap_mem0", fetch_data, 32'h12345678);
      fetch_addr = 1; tick(); check("gap_mem1", fetch_data, 32'h9ABCDEF0);

      // Illegal word counts with a byte left pending
      byte_valid = 1'b1; byte_data = 8'hAA;
      start = 1'b1; word_count = 0; tick(); start = 1'b0;
      check("wc0_err", err, 1);
      check("wc0_busy", busy, 0);
      check("wc0_ready", byte_ready, 0);
      start = 1'b1; word_count = 65; tick(); start = 1'b0;
      tick();
      check("wc65_err", err, 1);
      check("wc65_busy", busy, 0);
      check("wc65_ready", byte_ready, 0);
      check("wc65_hold", cpu_hold, 0);
      byte_valid = 1'b0;
      verify_known("illegal_mem");

      // A valid start clears err
      q.delete();
      repeat (4) q.push_back(8'($urandom));
      run_load(1, q, 0, 1'b1, 1'b0);

      // Full-depth load: word i holds i
      q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'(i));
      end
      run_load(DEPTH, q, 0, 1'b1, 1'b0);
      for (int a = 0; a < DEPTH; a++) begin
         fetch_addr = AW'(a);
         tick();
         check("full_fetch", fetch_data, 32'(a));
      end

      // Random-length loads with random bytes and gaps; first one pokes start mid-load
      for (int it = 0; it < 3; it++) begin
         n = $urandom_range(1, 8);
         q.delete();
         repeat (4 * n) q.push_back(8'($urandom));
         run_load(n, q, 2, 1'b1, it == 0);
      end
      verify_known("rand_mem");

      // Fetch of the address being written on the same edge returns the old word
      old_w = exp_mem[0];
      q.delete();
      repeat (4) q.push_back(8'($urandom) ^ 8'h5A);
      if (q[0] == old_w[31:24]) q[0] = ~q[0];
      do_start(1);
      fetch_addr = 0;
      foreach (q[i]) send_byte(q[i], 0);
      check("collide_old", fetch_data, old_w);
      tick();
      check("collide_new", fetch_data, pack_word(q, 0));
`ifdef LOADER_CHECKSUM_EN
      send_byte(q[0] ^ q[1] ^ q[2] ^ q[3], 0);
      tick();
`endif
      exp_mem[0] = pack_word(q, 0);
      check("collide_hold", cpu_hold, 0);

      // Reset after 5 bytes of a 3-word load
      q.delete();
      repeat (5) q.push_back(8'($urandom));
      do_start(3);
      foreach (q[i]) send_byte(q[i], 0);
      clkreset = 1'b1;
      tick();
      clkreset = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_hold", cpu_hold, 1);
      check("midrst_ww", words_written, 0);
      check("midrst_ready", byte_ready, 0);
      exp_mem[0] = pack_word(q, 0);
      fetch_check(0, "midrst_mem0");
      fetch_check(1, "midrst_mem1");
      q.delete();
      repeat (8) q.push_back(8'($urandom));
      run_load(2, q, 2, 1'b1, 1'b0);
      verify_known("after_rst_mem");

`ifdef LOADER_CHECKSUM_EN
      q = {8'h01, 8'h02, 8'h03, 8'h04};
      run_load(1, q, 0, 1'b1, 1'b0);
      run_load(1, q, 0, 1'b0, 1'b0);
      fetch_check(0, "csum_mem0");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write side of the processor's 64x32 instruction memory; the fetch stage is the read side.
- Accepts a byte stream over a valid/ready handshake and packs bytes MSB-first into 32-bit instruction words.
- Writes the words sequentially from address 0 and holds the CPU in reset until a load completes.
- Provides the registered 1-cycle fetch read port the PC/fetch logic uses.

Parameters:
- DEPTH, 64, number of instruction words.
- AW, 6, address width (log2 DEPTH).
- DW, 32, instruction word width; a multiple of 8, with bytes per word = DW/8.

Ports:
- clk  in  1  system clock
- clkreset  in  1  synchronous reset, active-high
- start  in  1  single-cycle request to begin a load
- word_count  in  AW+1  number of words to load; legal range 1..DEPTH
- byte_valid  in  1  byte_data is valid
- byte_data  in  8  stream byte
- byte_ready  out  1  loader accepts a byte this cycle
- busy  out  1  load in progress
- done  out  1  single-cycle pulse when a load completes
- cpu_hold  out  1  keeps the processor in reset
- words_written  out  AW+1  count of words written in the current or last load
- err  out  1  sticky error flag
- fetch_addr  in  AW  instruction fetch address (PC)
- fetch_data  out  DW  registered instruction word

Behaviour:
- Reset values: byte_ready=0, busy=0, done=0, cpu_hold=1, words_written=0, err=0, fetch_data=0, state=IDLE, internal pointers=0.
- Memory array contents are not reset.
- One clock domain; every register updates on the rising edge of clk.
- A byte transfer occurs on a cycle with byte_valid && byte_ready. Upstream holds byte_data stable until the transfer.

State machine (IDLE, LOAD, [CHECK], DONE):
- IDLE:
  - byte_ready=0 and busy=0; bytes presented in IDLE stay pending and are not consumed.
  - start with 1 <= word_count <= DEPTH: latch count, clear wr_ptr, byte_idx, words_written and err, set cpu_hold=1, go to LOAD.
  - start with word_count=0 or word_count>DEPTH: stay in IDLE, set err=1, no writes, cpu_hold unchanged.
- LOAD:
  - busy=1, byte_ready=1.
  - Each transfer shifts the byte into the accumulator MSB-first and increments byte_idx modulo DW/8.
  - On the transfer where byte_idx = DW/8-1:
    - mem[wr_ptr] <= {acc[DW-9:0], byte_data}, written on that same edge.
    - wr_ptr and words_written increment.
  - If that word is number count, go to DONE (or to CHECK when the feature is compiled in).
- DONE:
  - Lasts exactly 1 cycle; done=1, busy=1, byte_ready=0.
  - Next state IDLE; cpu_hold <= 0 on the same edge, unless an error was flagged by CHECK.
- start asserted while busy is ignored and has no effect on err.
- wr_ptr never wraps; a load of DEPTH words ends at address DEPTH-1.

Fetch port:
- fetch_data <= mem[fetch_addr] every cycle; latency 1 cycle.
- If a write and a fetch hit the same address on the same edge, fetch_data returns the old data; the new word is visible on the following read.
- The fetch port is always active, including during LOAD.

Reset mid-load:
- The load aborts and the state returns to IDLE with the reset values above.
- Words already written remain in memory; the partial word in the accumulator is discarded.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all accepted data bytes is kept, cleared on a valid start.
  - After the last word the FSM enters CHECK with byte_ready=1 and accepts exactly one checksum byte.
  - Mismatch: err=1, done still pulses, and cpu_hold stays 1.
  - Match: cpu_hold drops as normal.
- Undefined:
  - No CHECK state and no XOR logic; LOAD goes directly to DONE.
  - err is set only by an illegal word_count.

Test Plan:
- Reset, then start with word_count=2 and bytes 12 34 56 78 9A BC DE F0 streamed back-to-back -> mem[0]=0x12345678, mem[1]=0x9ABCDEF0. done pulses the cycle after the 8th transfer, cpu_hold=0 the cycle after that, words_written=2.
- Same load with byte_valid toggled every other cycle -> identical memory contents; done is delayed only by the gaps; no byte is dropped or duplicated.
- start with word_count=0, then word_count=65 -> err=1, state stays IDLE, byte_ready stays 0, memory unchanged. A following valid start clears err.
- Load 64 words of value i at address i, then drive fetch_addr 0..63 -> fetch_data equals fetch_addr one cycle later; address 63 is written and there is no wrap to 0.
- Assert clkreset after 5 bytes of a 3-word load -> mem[0] is written, mem[1] is untouched, busy=0, cpu_hold=1, words_written=0. A new load then completes normally.
- LOADER_CHECKSUM_EN: load 1 word (01 02 03 04) with checksum byte 0x04 -> err=0, cpu_hold=0. Repeat with checksum byte 0x05 -> err=1, done pulses, cpu_hold stays 1.
